// File: rtl/dshot_tx_pkg.sv
// Shared DShot constants, FSM state type and the frame checksum helper.
// The Q4.28 unit constant is the same one the motor mixer produces.
package dshot_tx_pkg;

    localparam int Q_FRAC_BITS = 28;
    localparam int DSHOT_MIN   = 48;
    localparam int DSHOT_MAX   = 2047;
    localparam int DSHOT_SCALE = 1999;
    localparam int FRAME_BITS  = 16;
    localparam int VALUE_BITS  = 11;

    localparam logic signed [31:0] Q_ONE = 32'sh1000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic logic [3:0] dshot_crc(input logic [11:0] v12);
        return v12[11:8] ^ v12[7:4] ^ v12[3:0];
    endfunction

endpackage

// File: rtl/dshot_tx_frame_encoder.sv
// Combinational throttle-to-frame encoder: clamp, scale into 48..2047,
// append the telemetry bit and the 4-bit checksum.
module dshot_tx_frame_encoder
    import dshot_tx_pkg::*;
(
    input  logic signed [31:0]           throttle_i,
    input  logic                         telem_i,
    output logic [VALUE_BITS-1:0]        value_o,
    output logic [FRAME_BITS-1:0]        frame_o
);

    logic [31:0] q;
    logic [39:0] prod;
    logic [11:0] v12;

    always_comb begin
        q       = '0;
        value_o = '0;
        if (throttle_i > Q_ONE) begin
            q = Q_ONE;
        end else if (throttle_i > 32'sd0) begin
            q = throttle_i;
        end
        prod = 40'(q) * 40'(DSHOT_SCALE);
        // Non-positive throttle is the motor-stop command, not the bottom of the range.
        if (throttle_i > 32'sd0) begin
            value_o = 11'(prod >> Q_FRAC_BITS) + 11'(DSHOT_MIN);
        end
    end

    assign v12     = {value_o, telem_i};
    assign frame_o = {v12, dshot_crc(v12)};

endmodule

// File: rtl/dshot_tx.sv
// Per-motor DShot transmitter: accepts a Q4.28 throttle word and serialises
// its 16-bit frame MSB-first, followed by a fixed low gap.
module dshot_tx
    import dshot_tx_pkg::*;
#(
    parameter int CLK_HZ   = 48_000_000,
    parameter int BIT_RATE = 600_000,
    parameter int GAP_CLKS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [31:0]    throttle_in,
    input  logic                  telem_req,
    input  logic                  throttle_valid,
    output logic                  throttle_ready,
    output logic                  dshot_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic [VALUE_BITS-1:0] last_value
);

    localparam int BIT_CLKS = CLK_HZ / BIT_RATE;
    localparam int T1H      = BIT_CLKS * 3 / 4;
    localparam int T0H      = BIT_CLKS * 3 / 8;
    localparam int CNT_W    = $clog2(BIT_CLKS);
    localparam int GAP_W    = $clog2(GAP_CLKS);
    localparam int IDX_W    = $clog2(FRAME_BITS);

    // Handshake: a word transfers on any rising edge where throttle_valid and
    // throttle_ready are both high; upstream holds its data until then.
    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [VALUE_BITS-1:0]   last_value_q, last_value_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic                    dshot_q, dshot_d;
    logic                    done_q, done_d;

    logic [VALUE_BITS-1:0]   enc_value;
    logic [FRAME_BITS-1:0]   enc_frame;
    logic [CNT_W-1:0]        high_len;
    logic                    accept;

    dshot_tx_frame_encoder u_encoder (
        .throttle_i (throttle_in),
        .telem_i    (telem_req),
        .value_o    (enc_value),
        .frame_o    (enc_frame)
    );

    assign throttle_ready = (state_q == ST_IDLE) && !reset;
    assign accept         = throttle_valid && throttle_ready;
    assign high_len       = frame_q[bit_idx_q] ? CNT_W'(T1H) : CNT_W'(T0H);

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        last_value_d = last_value_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        gap_cnt_d    = gap_cnt_q;
        dshot_d      = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_SEND;
                    frame_d      = enc_frame;
                    last_value_d = enc_value;
                    bit_cnt_d    = '0;
                    bit_idx_d    = IDX_W'(FRAME_BITS - 1);
                    // Every bit opens high, so the line rises the cycle after accept.
                    dshot_d      = 1'b1;
                end
            end
            ST_SEND: begin
                if (bit_cnt_q == CNT_W'(BIT_CLKS - 1)) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                        dshot_d   = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    dshot_d   = (bit_cnt_d < high_len);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CLKS - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            last_value_q <= '0;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            gap_cnt_q    <= '0;
            dshot_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            last_value_q <= last_value_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            dshot_q      <= dshot_d;
            done_q       <= done_d;
        end
    end

    assign dshot_out  = dshot_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign last_value = last_value_q;

endmodule

// File: tb/tb_dshot_tx.sv
// Directed and randomized bench for dshot_tx, checked against an arithmetic
// model of the throttle scaling and the DShot line waveform.
module tb_dshot_tx;

    localparam int BIT_CLKS   = 80;
    localparam int GAP_CLKS   = 64;
    localparam int FRAME_CLKS = 16 * BIT_CLKS;
    localparam int BUSY_CLKS  = FRAME_CLKS + GAP_CLKS;
    localparam int PERIOD     = BUSY_CLKS + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] throttle_in;
    logic               telem_req;
    logic               throttle_valid;
    logic               throttle_ready;
    logic               dshot_out;
    logic               busy;
    logic               frame_done;
    logic [10:0]        last_value;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    int          val_q[$];

    dshot_tx dut (
        .clk            (clk),
        .reset          (reset),
        .throttle_in    (throttle_in),
        .telem_req      (telem_req),
        .throttle_valid (throttle_valid),
        .throttle_ready (throttle_ready),
        .dshot_out      (dshot_out),
        .busy           (busy),
        .frame_done     (frame_done),
        .last_value     (last_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    // Reference: throttle as a real fraction of 1.0, clamped, mapped onto 48..2047.
    function automatic int model_value(input logic signed [31:0] t);
        longint q;
        if (t <= 0) return 0;
        q = (t > 32'sh1000_0000) ? 64'd268435456 : longint'(t);
        return int'(48 + (q * 1999) / 268435456);
    endfunction

    function automatic logic [15:0] model_frame(input int value, input logic telem);
        logic [11:0] v;
        logic [3:0]  c;
        v = {value[10:0], telem};
        c = 4'h0;
        for (int n = 0; n < 3; n++) c = c ^ v[n*4 +: 4];
        return {v, c};
    endfunction

    // Called at a negedge; returns #1 after the accepting edge (first SEND cycle).
    task automatic send(input logic signed [31:0] thr, input logic t);
        bit ok;
        throttle_in    = thr;
        telem_req      = t;
        throttle_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (throttle_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_seen", 32'(ok), 32'd1);
        exp_q.push_back(model_frame(model_value(thr), t));
        val_q.push_back(model_value(thr));
        @(posedge clk);
        #1;
        throttle_valid = 1'b0;
    endtask

    task automatic capture(input bit poke, output logic [15:0] got);
        logic [15:0] exp_f;
        int          exp_v;
        int          hi[16];
        int          wave_err, busy_err, done_err, rdy_err, lv_err;
        logic        e;
        exp_f = exp_q.pop_front();
        exp_v = val_q.pop_front();
        wave_err = 0; busy_err = 0; done_err = 0; rdy_err = 0; lv_err = 0;
        for (int j = 0; j < 16; j++) hi[j] = 0;
        for (int k = 0; k < BUSY_CLKS; k++) begin
            if (k < FRAME_CLKS) begin
                e = ((k % BIT_CLKS) < (exp_f[15 - k / BIT_CLKS] ? 60 : 30));
                if (dshot_out === 1'b1) hi[k / BIT_CLKS]++;
            end else begin
                e = 1'b0;
            end
            if (dshot_out !== e) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if (frame_done !== 1'b0) done_err++;
            if (throttle_ready !== 1'b0) rdy_err++;
            if (last_value !== 11'(exp_v)) lv_err++;
            if (poke && k == 300) begin
                throttle_in    = 32'sh0400_0000;
                telem_req      = 1'b1;
                throttle_valid = 1'b1;
            end
            if (poke && k == 301) throttle_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("wave_cycles_wrong", 32'(wave_err), 32'd0);
        check("busy_during_frame", 32'(busy_err), 32'd0);
        check("done_during_frame", 32'(done_err), 32'd0);
        check("ready_during_frame", 32'(rdy_err), 32'd0);
        check("last_value_during_frame", 32'(lv_err), 32'd0);
        check("frame_done_at_end", 32'(frame_done), 32'd1);
        check("busy_at_end", 32'(busy), 32'd0);
        check("ready_at_end", 32'(throttle_ready), 32'd1);
        for (int j = 0; j < 16; j++) got[15 - j] = (hi[j] > 45);
        check("decoded_frame", 32'(got), 32'(exp_f));
    endtask

    initial begin
        logic [15:0]        got;
        logic signed [31:0] thr;
        int acc[$];
        int runs[$];
        int rise_ok, done_cnt, low_run, err;
        logic prev_d;

        reset = 1'b1;
        throttle_in = '0;
        telem_req = 1'b0;
        throttle_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dshot", 32'(dshot_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_last_value", 32'(last_value), 32'd0);
        check("rst_ready", 32'(throttle_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(throttle_ready), 32'd1);

        // Directed frames
        @(negedge clk);
        send(32'sh1000_0000, 1'b0);
        capture(1'b0, got);
        check("full_scale_frame", 32'(got), 32'h0000_FFEE);
        check("full_scale_value", 32'(last_value), 32'd2047);

        @(negedge clk);
        send(32'sh0800_0000, 1'b1);
        capture(1'b0, got);
        check("half_scale_frame", 32'(got), 32'h0000_82F5);
        check("half_scale_value", 32'(last_value), 32'd1047);

        @(negedge clk);
        send(-32'sd5, 1'b0);
        capture(1'b0, got);
        check("negative_frame", 32'(got), 32'd0);

        @(negedge clk);
        send(32'sh7FFF_FFFF, 1'b0);
        capture(1'b0, got);
        check("clamp_frame", 32'(got), 32'h0000_FFEE);

        // Randomized frames across all throttle regions
        for (int r = 0; r < 6; r++) begin
            case ($urandom_range(0, 3))
                0: thr = $signed($urandom | 32'h8000_0000);
                1: thr = $signed(32'($urandom_range(1, 32'h1000_0000)));
                2: thr = $signed(32'($urandom_range(32'h1000_0001, 32'h7FFF_FFFF)));
                default: thr = $signed(32'($urandom_range(0, 1000)));
            endcase
            @(negedge clk);
            send(thr, 1'($urandom_range(0, 1)));
            capture(1'b0, got);
        end

        // Valid pulsed while busy is ignored
        @(negedge clk);
        send(32'sh0C00_0000, 1'b0);
        capture(1'b1, got);
        err = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy !== 1'b0 || dshot_out !== 1'b0) err++;
            if (last_value !== 11'(model_value(32'sh0C00_0000))) err++;
            @(posedge clk);
            #1;
        end
        check("no_frame_from_poke", 32'(err), 32'd0);

        // Back-to-back with valid held high
        @(negedge clk);
        throttle_in    = $signed(32'($urandom_range(1, 32'h1000_0000)));
        telem_req      = 1'b0;
        throttle_valid = 1'b1;
        rise_ok = 0; done_cnt = 0; low_run = 0; prev_d = 1'b0;
        for (int c = 0; c < 3 * PERIOD + 100; c++) begin
            if (acc.size() == 3 && !throttle_ready) throttle_valid = 1'b0;
            if (throttle_valid && throttle_ready) acc.push_back(c);
            if (frame_done === 1'b1) done_cnt++;
            if (throttle_ready === 1'b0) begin
                low_run++;
            end else begin
                if (low_run > 0) runs.push_back(low_run);
                low_run = 0;
            end
            if (acc.size() > 0 && c == acc[acc.size()-1] + 1 && dshot_out === 1'b1 && prev_d === 1'b0)
                rise_ok++;
            prev_d = dshot_out;
            @(negedge clk);
        end
        throttle_valid = 1'b0;
        check("b2b_accepts", 32'(acc.size()), 32'd3);
        check("b2b_spacing_1", 32'((acc.size() >= 2) ? acc[1] - acc[0] : -1), 32'(PERIOD));
        check("b2b_spacing_2", 32'((acc.size() >= 3) ? acc[2] - acc[1] : -1), 32'(PERIOD));
        check("b2b_first_rise", 32'(rise_ok), 32'd3);
        check("b2b_done_pulses", 32'(done_cnt), 32'd3);
        check("b2b_ready_runs", 32'(runs.size()), 32'd3);
        err = 0;
        foreach (runs[i]) if (runs[i] != BUSY_CLKS) err++;
        check("b2b_ready_low_len", 32'(err), 32'd0);

        // Reset in the middle of a frame
        @(negedge clk);
        send(32'sh1000_0000, 1'b0);
        for (int k = 0; k < 5 * BIT_CLKS + 20; k++) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_dshot", 32'(dshot_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(frame_done), 32'd0);
        check("midrst_ready_in_rst", 32'(throttle_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", 32'(throttle_ready), 32'd1);
        void'(exp_q.pop_front());
        void'(val_q.pop_front());
        err = 0;
        for (int k = 0; k < PERIOD + 50; k++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || dshot_out !== 1'b0 || busy !== 1'b0) err++;
        end
        check("midrst_no_done", 32'(err), 32'd0);
        send($signed(32'($urandom_range(1, 32'h1000_0000))), 1'b1);
        capture(1'b0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
